// File: rtl/ggt_result_uart_tx_if.sv
// ggt_result_uart_tx_if: result RAM read port, control handshake and UART line of the result transmitter
interface ggt_result_uart_tx_if #(parameter int ADDR_W = 8);
  logic              start_i;
  logic [ADDR_W-1:0] last_addr_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [15:0]       mem_q_i;
  logic              tx_o;
  logic              busy_o;
  logic              done_o;
  modport master (output start_i, last_addr_i, mem_q_i, input mem_addr_o, tx_o, busy_o, done_o);
  modport slave (input start_i, last_addr_i, mem_q_i, output mem_addr_o, tx_o, busy_o, done_o);
endinterface

// File: rtl/ggt_result_uart_tx.sv
// ggt_result_uart_tx: reads GCD results 0..last from RAM and sends each 16-bit word as two 8N1 bytes, high byte first
module ggt_result_uart_tx #(
  parameter int CLK_DIV = 434,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 2
) (
  input logic                 clk,
  input logic                 rst_i,
  ggt_result_uart_tx_if.slave bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(RD_LAT + 3);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, SHIFT, NEXT, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic [15:0]       r_word;
  logic              r_hi;
  logic [3:0]        r_bit;
  logic [DW-1:0]     r_div;
  logic [CW-1:0]     r_cnt;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        w_byte;
  logic              w_div_end;
  logic              w_next_tx;
  assign bus.mem_addr_o = r_addr;
  assign bus.tx_o       = r_tx;
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  // current byte and the level of the frame bit that follows r_bit (data LSB first, then stop)
  always_comb begin
    w_byte    = r_hi ? r_word[15:8] : r_word[7:0];
    w_div_end = r_div == DW'(CLK_DIV - 1);
    w_next_tx = (r_bit == 4'd8) ? 1'b1 : w_byte[r_bit[2:0]];
  end
  // readout sequencer and bit serialiser; SHIFT leaves one cycle before the last stop bit ends so the
  // tx register still holds the stop level while NEXT decides, and NEXT pads the line for two more cycles
  // before stepping the address so the inter-word gap is RD_LAT+3 cycles
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_last  <= '0;
      r_word  <= '0;
      r_hi    <= 1'b0;
      r_bit   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start_i) begin
          r_last  <= bus.last_addr_i;
          r_addr  <= '0;
          r_busy  <= 1'b1;
          r_state <= ADDR;
        end
        ADDR: begin
          r_cnt   <= CW'(1);
          r_state <= (RD_LAT == 1) ? LOAD : WAIT;
        end
        WAIT: if (r_cnt == CW'(RD_LAT - 1)) r_state <= LOAD;
              else r_cnt <= r_cnt + 1'b1;
        LOAD: begin
          r_word  <= bus.mem_q_i;
          r_hi    <= 1'b1;
          r_bit   <= '0;
          r_div   <= '0;
          r_tx    <= 1'b0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_div <= w_div_end ? '0 : r_div + 1'b1;
          if (r_bit == 4'd9 && !r_hi && r_div == DW'(CLK_DIV - 2)) begin
            r_cnt   <= '0;
            r_state <= NEXT;
          end else if (w_div_end) begin
            if (r_bit == 4'd9) begin
              r_hi  <= 1'b0;
              r_bit <= '0;
              r_tx  <= 1'b0;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= w_next_tx;
            end
          end
        end
        NEXT: if (r_addr == r_last) begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end else if (r_cnt == CW'(2)) begin
          r_addr  <= r_addr + 1'b1;
          r_state <= ADDR;
        end else r_cnt <= r_cnt + 1'b1;
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ggt_result_uart_tx.sv
// tb_ggt_result_uart_tx: directed checks of the result RAM readout and 8N1 serial stream
module tb_ggt_result_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int ADDR_W  = 2;
  localparam int RD_LAT  = 2;
  localparam int WORD    = 20 * CLK_DIV;
  localparam int PITCH   = WORD + RD_LAT + 3;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [15:0] ram [4];
  logic [15:0] p1;
  logic tx_log [4096];
  logic done_log [4096];
  logic busy_log [4096];
  logic [ADDR_W-1:0] addr_log [4096];
  ggt_result_uart_tx_if #(.ADDR_W(ADDR_W)) bus ();
  ggt_result_uart_tx #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst_i(rst_i), .bus(bus));
  always #5 clk = ~clk;
  // cycle counter and a RAM whose data trails the address by RD_LAT cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1 <= ram[bus.mem_addr_o];
    bus.mem_q_i <= p1;
  end
  // per-cycle record of the outputs, sampled mid-cycle
  always @(negedge clk) begin
    if (cyc < 4096) begin
      tx_log[cyc] = bus.tx_o;
      done_log[cyc] = bus.done_o;
      busy_log[cyc] = bus.busy_o;
      addr_log[cyc] = bus.mem_addr_o;
    end
  end
  function automatic int frame_errs(input int s, input logic [15:0] w);
    int e = 0;
    logic [9:0] f;
    for (int b = 0; b < 2; b++) begin
      f = {1'b1, (b == 0) ? w[15:8] : w[7:0], 1'b0};
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < CLK_DIV; j++)
          if (tx_log[s + b*10*CLK_DIV + k*CLK_DIV + j] !== f[k]) e++;
    end
    return e;
  endfunction
  function automatic int done_count(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (done_log[i] === 1'b1) n++;
    return n;
  endfunction
  task automatic pulse_start(input logic [ADDR_W-1:0] last, output int c);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.last_addr_i = last;
    c = cyc;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.start_i = 1'($urandom_range(0, 1));
      bus.last_addr_i = ADDR_W'($urandom);
    end
    @(negedge clk);
    tests++; if (bus.tx_o !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", bus.tx_o); end
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    tests++; if (bus.mem_addr_o !== '0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr_o); end
    rst_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_single;
    int c, e;
    ram[0] = 16'h0005;
    pulse_start(2'd0, c);
    repeat (100) @(negedge clk);
    tests++; if (tx_log[c+3] !== 1'b1) begin fails++; $display("FAIL single_idle_before: got %b expected 1", tx_log[c+3]); end
    tests++; if (tx_log[c+4] !== 1'b0) begin fails++; $display("FAIL single_start_edge: got %b expected 0", tx_log[c+4]); end
    e = frame_errs(c + 4, 16'h0005);
    tests++; if (e !== 0) begin fails++; $display("FAIL single_frame: got %0d bad cycles expected 0", e); end
    tests++; if (done_log[c+84] !== 1'b1) begin fails++; $display("FAIL single_done_time: got %b expected 1", done_log[c+84]); end
    e = done_count(c, c + 99);
    tests++; if (e !== 1) begin fails++; $display("FAIL single_done_count: got %0d expected 1", e); end
    e = 0;
    for (int i = c; i <= c + 86; i++) if (busy_log[i] !== ((i >= c + 1) && (i <= c + 84))) e++;
    tests++; if (e !== 0) begin fails++; $display("FAIL single_busy: got %0d bad cycles expected 0", e); end
  endtask
  task automatic test_multi;
    int c, s0, e, g;
    logic [15:0] exp_w [3];
    exp_w = '{16'h002D, 16'h0001, 16'hFFFF};
    ram[0] = 16'h002D; ram[1] = 16'h0001; ram[2] = 16'hFFFF;
    pulse_start(2'd2, c);
    s0 = c + 4;
    repeat (3*PITCH + 30) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      e = frame_errs(s0 + w*PITCH, exp_w[w]);
      tests++; if (e !== 0) begin fails++; $display("FAIL multi_frame%0d: got %0d bad cycles expected 0", w, e); end
    end
    for (int w = 0; w < 2; w++) begin
      g = 0;
      while (g < 20 && tx_log[s0 + w*PITCH + WORD + g] === 1'b1) g++;
      tests++; if (g !== 5) begin fails++; $display("FAIL multi_gap%0d: got %0d cycles expected 5", w, g); end
    end
    for (int w = 0; w < 3; w++) begin
      tests++; if (addr_log[s0 + w*PITCH + 40] !== ADDR_W'(w)) begin fails++; $display("FAIL multi_addr%0d: got %0d expected %0d", w, addr_log[s0 + w*PITCH + 40], w); end
    end
    tests++; if (addr_log[s0 + 2*PITCH + WORD + 10] !== 2'd2) begin fails++; $display("FAIL multi_addr_hold: got %0d expected 2", addr_log[s0 + 2*PITCH + WORD + 10]); end
    tests++; if (done_log[s0 + 2*PITCH + WORD] !== 1'b1) begin fails++; $display("FAIL multi_done_time: got %b expected 1", done_log[s0 + 2*PITCH + WORD]); end
  endtask
  task automatic test_start_busy;
    int c, e;
    ram[0] = 16'h1234;
    pulse_start(2'd0, c);
    repeat (19) @(negedge clk);
    bus.start_i = 1'b1;
    bus.last_addr_i = 2'd3;
    ram[0] = 16'hBEEF;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (40) @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (80) @(negedge clk);
    e = frame_errs(c + 4, 16'h1234);
    tests++; if (e !== 0) begin fails++; $display("FAIL busy_frame: got %0d bad cycles expected 0", e); end
    tests++; if (done_log[c+84] !== 1'b1) begin fails++; $display("FAIL busy_done_time: got %b expected 1", done_log[c+84]); end
    e = done_count(c, c + 140);
    tests++; if (e !== 1) begin fails++; $display("FAIL busy_done_count: got %0d expected 1", e); end
    e = 0;
    for (int i = c + 85; i <= c + 140; i++) if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) e++;
    tests++; if (e !== 0) begin fails++; $display("FAIL busy_no_restart: got %0d active cycles expected 0", e); end
  endtask
  task automatic test_reset_mid;
    int c, x, e;
    ram[0] = 16'h002D; ram[1] = 16'h0001; ram[2] = 16'hFFFF;
    pulse_start(2'd2, c);
    x = c + 4 + PITCH + 49;
    while (cyc < x) @(negedge clk);
    rst_i = 1'b1;
    bus.start_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (150) @(negedge clk);
    tests++; if (tx_log[x] !== 1'b0) begin fails++; $display("FAIL rstmid_pre_tx: got %b expected 0", tx_log[x]); end
    tests++; if (tx_log[x+1] !== 1'b1) begin fails++; $display("FAIL rstmid_tx: got %b expected 1", tx_log[x+1]); end
    tests++; if (addr_log[x+1] !== '0) begin fails++; $display("FAIL rstmid_addr: got %0d expected 0", addr_log[x+1]); end
    e = 0;
    for (int i = x + 1; i <= x + 149; i++) if (busy_log[i] !== 1'b0 || tx_log[i] !== 1'b1) e++;
    tests++; if (e !== 0) begin fails++; $display("FAIL rstmid_start_ignored: got %0d active cycles expected 0", e); end
    e = done_count(c, x + 149);
    tests++; if (e !== 0) begin fails++; $display("FAIL rstmid_no_done: got %0d expected 0", e); end
    ram[0] = 16'hA55A;
    pulse_start(2'd0, c);
    repeat (100) @(negedge clk);
    e = frame_errs(c + 4, 16'hA55A);
    tests++; if (e !== 0) begin fails++; $display("FAIL rstmid_restart_frame: got %0d bad cycles expected 0", e); end
    tests++; if (done_log[c+84] !== 1'b1) begin fails++; $display("FAIL rstmid_restart_done: got %b expected 1", done_log[c+84]); end
  endtask
  task automatic test_full_range;
    int c, s0, e;
    for (int i = 0; i < 4; i++) ram[i] = 16'(i + 1);
    pulse_start(2'd3, c);
    s0 = c + 4;
    repeat (4*PITCH + 30) @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      e = frame_errs(s0 + w*PITCH, 16'(w + 1));
      tests++; if (e !== 0) begin fails++; $display("FAIL full_frame%0d: got %0d bad cycles expected 0", w, e); end
    end
    e = done_count(c, c + 4*PITCH + 25);
    tests++; if (e !== 1) begin fails++; $display("FAIL full_done_count: got %0d expected 1", e); end
    tests++; if (done_log[s0 + 3*PITCH + WORD] !== 1'b1) begin fails++; $display("FAIL full_done_time: got %b expected 1", done_log[s0 + 3*PITCH + WORD]); end
    e = 0;
    for (int i = c + 2; i <= c + 4*PITCH + 25; i++) if (addr_log[i] < addr_log[i-1]) e++;
    tests++; if (e !== 0) begin fails++; $display("FAIL full_no_wrap: got %0d decreases expected 0", e); end
    tests++; if (addr_log[s0 + 3*PITCH + WORD + 10] !== 2'd3) begin fails++; $display("FAIL full_addr_hold: got %0d expected 3", addr_log[s0 + 3*PITCH + WORD + 10]); end
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.last_addr_i = '0;
    for (int i = 0; i < 4; i++) ram[i] = '0;
    test_reset;
    test_single;
    test_multi;
    test_start_busy;
    test_reset_mid;
    test_full_range;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/ggt_result_uart_tx.md
Name: ggt_result_uart_tx

Overview:
Reader and transmitter for the GCD result memory. The GCD datapath writes results into a single-port result RAM. This block reads words back from address 0 up to a programmable last address and serialises each 16-bit result over a UART TX line (8N1), high byte first. It sits between the result RAM read port and the board's serial pin, so results can be checked on a host PC without simulation file I/O.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (434 = 115200 baud at 50 MHz); legal range is 2 or more.
ADDR_W, 8, result RAM address width.
RD_LAT, 2, result RAM read latency in cycles, from mem_addr_o change to valid mem_q_i; legal range is 1 or more.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  start a readout; sampled only in IDLE.
last_addr_i  in  ADDR_W  last address to send (inclusive); sampled with start_i.
mem_addr_o  out  ADDR_W  result RAM read address.
mem_q_i  in  16  result RAM read data.
tx_o  out  1  UART serial output; idle level is high.
busy_o  out  1  high from the cycle after start is accepted until the cycle done_o pulses (inclusive).
done_o  out  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk, reset port is rst_i.
- Reset values: tx_o=1, busy_o=0, done_o=0, mem_addr_o=0. FSM goes to IDLE, all counters are cleared.
- Reset asserted mid-frame aborts the readout. tx_o is 1 on the cycle after the reset edge. No done_o pulse is produced.
- FSM states are IDLE, ADDR, WAIT, LOAD, SHIFT, NEXT, DONE.
- IDLE:
  - Waits for start_i=1.
  - On acceptance, latches last_addr_i, sets mem_addr_o=0 and goes to ADDR.
  - start_i in any state other than IDLE is ignored.
- ADDR/WAIT: holds mem_addr_o and counts RD_LAT cycles from the address change.
- LOAD:
  - Captures mem_q_i into a 16-bit shift word.
  - Selects the high byte [15:8] and goes to SHIFT.
- SHIFT (byte serialiser):
  - Frame is start bit 0, then data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLK_DIV cycles, so one byte takes 10*CLK_DIV cycles.
  - After the high byte, the low byte [7:0] starts on the next cycle with no idle gap.
  - After the low byte stop bit, go to NEXT.
- NEXT:
  - If mem_addr_o equals the latched last address, go to DONE.
  - Otherwise increment mem_addr_o and go to ADDR. tx_o stays 1 during this inter-word gap.
- DONE: done_o=1 for one cycle, busy_o falls, then return to IDLE. mem_addr_o holds its last value.
- Timing for cycle c = start accepted:
  - mem_addr_o=0 is visible in cycle c+1.
  - Data is captured at c+1+RD_LAT.
  - The first start bit (tx_o=0) begins at c+2+RD_LAT.
- Per-word timing:
  - Each word occupies 20*CLK_DIV cycles on the line.
  - The idle gap between words is exactly RD_LAT+3 cycles.
- Boundary conditions:
  - last_addr_i=0 sends exactly one word.
  - last_addr_i = 2^ADDR_W - 1 sends all words. The address does not wrap, because NEXT compares before incrementing.
- A simultaneous start_i and rst_i in the same cycle resolves to reset: start is ignored.
- mem_q_i is sampled only in LOAD. Changes on it at any other time have no effect.
- tx_o is driven from a register, so it carries no combinational glitches.

Test Plan:
All scenarios use CLK_DIV=4 and RD_LAT=2.
1. Reset: rst_i=1 for 2 cycles with random inputs -> tx_o=1, busy_o=0, done_o=0, mem_addr_o=0.
2. Single word: RAM[0]=16'h0005, last_addr_i=0, start_i pulse at cycle c:
   - tx_o falls at c+4.
   - Line carries byte 0x00 then byte 0x05: bits 0,00000000,1,0,10100000,1, each 4 cycles.
   - done_o pulses at c+84.
   - busy_o is high on cycles c+1 to c+84.
3. Multi word: RAM[0..2]=16'h002D, 16'h0001, 16'hFFFF, last_addr_i=2:
   - Bytes decoded are 00 2D 00 01 FF FF.
   - The idle gap between words is 5 cycles.
   - mem_addr_o steps 0, 1, 2, then holds at 2.
4. Start while busy: re-pulse start_i in mid-frame -> ignored; byte stream and done_o timing are unchanged.
5. Reset mid-frame: rst_i during the low byte of word 1 -> tx_o=1 on the next cycle, no done_o. A new start afterwards sends from address 0 correctly.
6. Full range with ADDR_W=2: last_addr_i=3, RAM[i]=i+1 -> 4 words 0001..0004 are sent, mem_addr_o never wraps, and exactly one done_o pulse is produced.
